// File: rtl/ariane_pkg.sv
// Shared flush-target bit map and the fence.t sequencer state type.
// No ports: imported by fence_t_sequencer.
package ariane_pkg;

  // Bit positions in the flush mask / flush vector.
  localparam int FT_IF       = 0;
  localparam int FT_UNISSUED = 1;
  localparam int FT_ID       = 2;
  localparam int FT_EX       = 3;
  localparam int FT_DCACHE   = 4;
  localparam int FT_ICACHE   = 5;
  localparam int FT_TLB      = 6;
  localparam int FT_BP       = 7;
  localparam int FT_DLFSR    = 8;
  localparam int FT_ILFSR    = 9;
  localparam int FT_PLRU     = 10;
  localparam int FT_MEMARB   = 11;
  localparam int FT_WBARB    = 12;
  localparam int FT_DFIFO    = 13;

  // The D$ wait state is called FT_DCACHE_FLUSH because the name FT_DCACHE
  // already denotes the flush bit index above.
  typedef enum logic [2:0] {
    FT_IDLE,
    FT_PIPE,
    FT_DCACHE_FLUSH,
    FT_PAD,
    FT_DONE
  } fence_t_state_e;

endpackage

// File: rtl/fence_t_sequencer.sv
// fence_t_sequencer
//   Turns one fence.t request into ordered flush phases: a one-cycle pulse of
//   the pipeline/microarchitectural flush bits, then the D$ flush held until
//   the cache acks, then padding so the whole operation takes a fixed latency.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/ready_o    request handshake from commit (accept = valid & ready)
//   req_mask_i             flush targets, sampled on accept
//   pad_cycles_i           required total latency (0 = none), sampled on accept
//   flush_o                flush vector to the flush controller
//   dcache_flush_ack_i     D$ flush complete
//   halt_o                 stall commit while busy
//   set_pc_o, done_o       one-cycle completion pulses
//   overrun_o              with done_o: natural latency exceeded pad_cycles
module fence_t_sequencer
  import ariane_pkg::*;
#(
  parameter int unsigned NrFlush  = 14,
  parameter int unsigned PadWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [NrFlush-1:0]  req_mask_i,
  input  logic [PadWidth-1:0] pad_cycles_i,
  output logic [NrFlush-1:0]  flush_o,
  input  logic                dcache_flush_ack_i,
  output logic                halt_o,
  output logic                set_pc_o,
  output logic                done_o,
  output logic                overrun_o
);

  localparam logic [NrFlush-1:0] DcacheBit = NrFlush'(1) << FT_DCACHE;
  localparam logic [PadWidth:0]  One       = (PadWidth+1)'(1);

  fence_t_state_e        state_q, state_d;
  logic [NrFlush-1:0]    mask_q;
  logic [PadWidth-1:0]   pad_q;
  logic [PadWidth-1:0]   elapsed_q;
  logic                  accept;
  logic [PadWidth:0]     elapsed_inc;
  logic                  pad_reached;

  assign accept = (state_q == FT_IDLE) && req_valid_i;

  // elapsed_q counts the cycle being executed, so PAD leaves one cycle early
  // to land DONE exactly on cycle T+pad. Extra bit keeps the +1 from wrapping.
  assign elapsed_inc = {1'b0, elapsed_q} + One;
  assign pad_reached = (pad_q == '0) || (elapsed_inc >= {1'b0, pad_q});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FT_IDLE;
      mask_q    <= '0;
      pad_q     <= '0;
      elapsed_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mask_q    <= req_mask_i;
        pad_q     <= pad_cycles_i;
        elapsed_q <= PadWidth'(1);
      end else if (state_q != FT_IDLE && elapsed_q != '1) begin
        // saturate rather than wrap so a very long D$ flush cannot re-arm the pad compare
        elapsed_q <= elapsed_q + PadWidth'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    flush_o     = '0;
    halt_o      = 1'b1;
    set_pc_o    = 1'b0;
    done_o      = 1'b0;
    overrun_o   = 1'b0;
    case (state_q)
      FT_IDLE: begin
        req_ready_o = 1'b1;
        halt_o      = 1'b0;
        if (req_valid_i) state_d = FT_PIPE;
      end
      FT_PIPE: begin
        // D$ flush is issued separately because it is a multi-cycle handshake
        flush_o = mask_q & ~DcacheBit;
        state_d = mask_q[FT_DCACHE] ? FT_DCACHE_FLUSH : FT_PAD;
      end
      FT_DCACHE_FLUSH: begin
        flush_o = DcacheBit;
        if (dcache_flush_ack_i) state_d = FT_PAD;
      end
      FT_PAD: begin
        if (pad_reached) state_d = FT_DONE;
      end
      FT_DONE: begin
        done_o    = 1'b1;
        set_pc_o  = 1'b1;
        overrun_o = (pad_q != '0) && (elapsed_q > pad_q);
        state_d   = FT_IDLE;
      end
      default: begin
        state_d = FT_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fence_t_sequencer.sv
module tb_fence_t_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [13:0] req_mask_i = '0;
  logic [15:0] pad_cycles_i = '0;
  logic [13:0] flush_o;
  logic        dcache_flush_ack_i = 1'b0;
  logic        halt_o;
  logic        set_pc_o;
  logic        done_o;
  logic        overrun_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fence_t_sequencer #(.NrFlush(14), .PadWidth(16)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_mask_i         (req_mask_i),
    .pad_cycles_i       (pad_cycles_i),
    .flush_o            (flush_o),
    .dcache_flush_ack_i (dcache_flush_ack_i),
    .halt_o             (halt_o),
    .set_pc_o           (set_pc_o),
    .done_o             (done_o),
    .overrun_o          (overrun_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- behavioural model (offsets from the accept cycle) ----------------
  bit          m_active = 1'b0;
  bit          m_acked  = 1'b0;
  int          m_t = 0;
  int          m_a = 0;
  int          m_pad = 0;
  logic [13:0] m_mask = '0;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Offset of the done cycle; -1 while it still depends on a D$ ack not yet seen.
  function automatic int done_k();
    if (!m_mask[4]) return imax(m_pad, 3);
    if (m_acked) return imax(m_pad, m_a + 2);
    return -1;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_active <= 1'b0;
      m_acked  <= 1'b0;
    end else if (!m_active) begin
      if (req_valid_i) begin
        m_active <= 1'b1;
        m_acked  <= 1'b0;
        m_t      <= cyc;
        m_mask   <= req_mask_i;
        m_pad    <= int'(pad_cycles_i);
        $display("txn accept cyc=%0d mask=%04h pad=%0d", cyc, req_mask_i, pad_cycles_i);
      end
    end else begin
      if (m_mask[4] && !m_acked && (cyc - m_t) >= 2 && dcache_flush_ack_i) begin
        m_acked <= 1'b1;
        m_a     <= cyc - m_t;
      end
      if ((cyc - m_t) == done_k()) m_active <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    logic        e_rdy, e_halt, e_done, e_ovr;
    logic [13:0] e_flush;
    int          k, dk;
    e_rdy = 1'b1; e_halt = 1'b0; e_done = 1'b0; e_ovr = 1'b0; e_flush = '0;
    if (rst_ni && m_active) begin
      k  = cyc - m_t;
      dk = done_k();
      e_rdy  = 1'b0;
      e_halt = 1'b1;
      if (k == 1) e_flush = m_mask & ~14'h0010;
      else if (m_mask[4] && !m_acked) e_flush = 14'h0010;
      e_done = (k == dk);
      e_ovr  = e_done && (m_pad != 0) && (dk > m_pad);
    end
    checks++;
    if ({req_ready_o, halt_o, flush_o, done_o, set_pc_o, overrun_o} !==
        {e_rdy, e_halt, e_flush, e_done, e_done, e_ovr}) begin
      errors++;
      $display("FAIL cycle cyc=%0d got rdy=%b halt=%b flush=%04h done=%b setpc=%b ovr=%b expected rdy=%b halt=%b flush=%04h done=%b setpc=%b ovr=%b",
               cyc, req_ready_o, halt_o, flush_o, done_o, set_pc_o, overrun_o,
               e_rdy, e_halt, e_flush, e_done, e_done, e_ovr);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (m_active && guard < 70000) begin
      tick();
      guard++;
    end
    if (m_active) begin
      errors++;
      $display("FAIL idle_timeout cyc=%0d got=busy expected=idle", cyc);
    end
  endtask

  task automatic accept(input logic [13:0] mask, input logic [15:0] pad, output int t);
    req_valid_i  = 1'b1;
    req_mask_i   = mask;
    pad_cycles_i = pad;
    t = cyc;
    tick();
    req_valid_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #1;
    chk("reset_ready", 32'(req_ready_o), 32'd1);
    chk("reset_flush", 32'(flush_o), 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // no D$, no padding
    accept(14'h0001, 16'd0, t);
    wait_cyc(t + 1); @(negedge clk_i); chk("t1_flush_pipe", 32'(flush_o), 32'h0001);
    wait_cyc(t + 2); @(negedge clk_i); chk("t1_flush_pad", 32'(flush_o), 32'h0000);
    wait_cyc(t + 3); @(negedge clk_i);
    chk("t1_done", 32'(done_o), 32'd1);
    chk("t1_setpc", 32'(set_pc_o), 32'd1);
    chk("t1_ovr", 32'(overrun_o), 32'd0);
    wait_idle();

    // D$ with padding covering the flush
    accept(14'h0011, 16'd20, t);
    wait_cyc(t + 2); @(negedge clk_i); chk("t2_flush_d_first", 32'(flush_o), 32'h0010);
    wait_cyc(t + 7); dcache_flush_ack_i = 1'b1;
    @(negedge clk_i); chk("t2_flush_ack_cycle", 32'(flush_o), 32'h0010);
    tick(); dcache_flush_ack_i = 1'b0;
    @(negedge clk_i); chk("t2_flush_after", 32'(flush_o), 32'h0000);
    wait_cyc(t + 19); @(negedge clk_i); chk("t2_not_early", 32'(done_o), 32'd0);
    wait_cyc(t + 20); @(negedge clk_i);
    chk("t2_done", 32'(done_o), 32'd1);
    chk("t2_ovr", 32'(overrun_o), 32'd0);
    wait_idle();

    // D$ ack late: overrun
    accept(14'h0010, 16'd5, t);
    wait_cyc(t + 10); dcache_flush_ack_i = 1'b1; tick(); dcache_flush_ack_i = 1'b0;
    wait_cyc(t + 12); @(negedge clk_i);
    chk("t3_done", 32'(done_o), 32'd1);
    chk("t3_ovr", 32'(overrun_o), 32'd1);
    chk("t3_halt", 32'(halt_o), 32'd1);
    wait_cyc(t + 13); @(negedge clk_i); chk("t3_halt_off", 32'(halt_o), 32'd0);
    wait_idle();

    // held request and spurious ack in PAD
    req_valid_i = 1'b1; req_mask_i = 14'h0011; pad_cycles_i = 16'd10;
    t = cyc; tick();
    req_mask_i = 14'h0002; pad_cycles_i = 16'd4;
    wait_cyc(t + 3); dcache_flush_ack_i = 1'b1; tick(); dcache_flush_ack_i = 1'b0;
    wait_cyc(t + 5); dcache_flush_ack_i = 1'b1; tick(); dcache_flush_ack_i = 1'b0;
    wait_cyc(t + 10); @(negedge clk_i);
    chk("t5_done", 32'(done_o), 32'd1);
    chk("t5_ready_in_done", 32'(req_ready_o), 32'd0);
    wait_cyc(t + 11); @(negedge clk_i); chk("t5_ready_after", 32'(req_ready_o), 32'd1);
    wait_cyc(t + 12); @(negedge clk_i); chk("t5_second_pipe", 32'(flush_o), 32'h0002);
    tick(); req_valid_i = 1'b0;
    wait_idle();

    // reset during the D$ wait
    accept(14'h0010, 16'd30, t);
    wait_cyc(t + 4);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_rst_flush", 32'(flush_o), 32'h0000);
    chk("t6_rst_halt", 32'(halt_o), 32'd0);
    chk("t6_rst_ready", 32'(req_ready_o), 32'd1);
    tick(); rst_ni = 1'b1;
    dcache_flush_ack_i = 1'b1; tick(); tick(); dcache_flush_ack_i = 1'b0;
    @(negedge clk_i);
    chk("t6_ack_ignored_halt", 32'(halt_o), 32'd0);
    chk("t6_ack_ignored_flush", 32'(flush_o), 32'h0000);
    tick();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      req_valid_i        = ($urandom_range(0, 2) == 0);
      req_mask_i         = 14'($urandom);
      pad_cycles_i       = 16'($urandom_range(0, 24));
      dcache_flush_ack_i = ($urandom_range(0, 3) == 0);
      tick();
    end
    req_valid_i = 1'b0; dcache_flush_ack_i = 1'b0;
    wait_idle();

    // maximum padding, saturating counter
    accept(14'h0000, 16'hFFFF, t);
    wait_cyc(t + 65534); @(negedge clk_i); chk("t4_not_early", 32'(done_o), 32'd0);
    wait_cyc(t + 65535); @(negedge clk_i);
    chk("t4_done", 32'(done_o), 32'd1);
    chk("t4_ovr", 32'(overrun_o), 32'd0);
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
